// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bundle: imem request/response, redirect, decode handoff
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I fetch stage: PC, credit-limited imem requests, in-order fetch queue
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = 8;
    localparam int UW = OW + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_resp_pc;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   r_drop;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            r_fault;
    logic [31:0]     r_q_data [DEPTH];
    logic [31:0]     r_q_pc   [DEPTH];

    logic            w_redirect;
    logic            w_misaligned;
    logic            w_req_valid;
    logic            w_fire;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic            w_instr_valid;
    logic            w_credit_ok;
    logic [UW-1:0]   w_used;
    logic [OW-1:0]   w_out_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_redirect    = bus.redirect_valid;
    assign w_misaligned  = (bus.redirect_pc[1:0] != 2'b00);
    assign w_instr_valid = (r_count != '0) && !w_redirect;
    assign w_pop         = w_instr_valid && bus.instr_ready;
    // Responses with nothing outstanding are stale traffic from before a reset.
    assign w_resp        = bus.imem_resp_valid && (r_outstanding != '0);
    assign w_push        = w_resp && (r_drop == '0) && !w_redirect;
    assign w_fire        = w_req_valid && bus.imem_req_ready;
    assign w_out_next    = r_outstanding + OW'(w_fire) - OW'(w_resp);

    // A slot freed by this cycle's pop is reusable at once, giving one fetch per cycle.
    assign w_used        = UW'(r_outstanding - r_drop) + UW'(r_count) - UW'(w_pop);
    assign w_credit_ok   = (w_used < UW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_redirect) begin
            w_state_next = w_misaligned ? ST_HALT : ST_RUN;
        end
    end

    always_comb begin
        w_req_valid = 1'b0;
        if (rst_n && (r_state == ST_RUN) && !w_redirect && w_credit_ok) begin
            w_req_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_redirect) begin
                r_fetch_pc <= bus.redirect_pc;
                r_resp_pc  <= bus.redirect_pc;
                r_drop     <= w_out_next;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fault    <= w_misaligned;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_resp && (r_drop != '0)) begin
                    r_drop <= r_drop - OW'(1);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wr_ptr  <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= bus.imem_resp_data;
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr          = (r_count != '0) ? r_q_data[r_rd_ptr] : 32'h0;
    assign bus.instr_pc       = (r_count != '0) ? r_q_pc[r_rd_ptr]   : 32'h0;
    assign bus.fetch_fault    = r_fault;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a fixed-latency memory and pop log
module tb_instr_fetch;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ecount   = 0;
    int          fire_cnt = 0;
    int          mem_lat  = 1;
    int          rel      = 0;
    mreq_t       mq[$];
    logic [31:0] pop_pc[$];
    int          pop_edge[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observe the upcoming edge 1 time unit before it; ecount becomes that edge's number.
    always @(negedge clk) begin
        #4;
        ecount++;
        if (rst_n) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{bus.imem_req_addr, ecount + mem_lat});
                fire_cnt++;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                pop_pc.push_back(bus.instr_pc);
                pop_edge.push_back(ecount);
                check("instr_tag", bus.instr, ~bus.instr_pc);
            end
            if (dut.w_push) begin
                check("no_push_full", 32'(dut.r_count == CW_DEPTH()), 32'h0);
            end
        end
    end

    function automatic int CW_DEPTH();
        return DEPTH;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end else if (mq.size() != 0 && mq[0].due == ecount + 1) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = ~mq[0].addr;
            void'(mq.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        pop_pc.delete();
        pop_edge.delete();
        fire_cnt = 0;
    endtask

    function automatic logic [31:0] pc_at(input int i);
        return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int edge_at(input int i);
        return (i < pop_edge.size()) ? pop_edge[i] : -1000;
    endfunction

    task automatic do_reset(input int lat, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = rdy;
        mem_lat            = lat;
        cyc(2);
        rst_n = 1'b1;
        rel   = ecount;
        clear_log();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        clear_log();
        cyc(1);
        bus.redirect_valid = 1'b0;
        clear_log();
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        #2;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_fault", 32'(bus.fetch_fault), 32'h0);

        // Stream: first delivery 2 cycles after release, then one per cycle.
        cyc(2);
        rst_n = 1'b1;
        rel   = ecount;
        clear_log();
        cyc(8);
        check("stream_pc0", pc_at(0), 32'h0);
        check("stream_pc1", pc_at(1), 32'h4);
        check("stream_pc2", pc_at(2), 32'h8);
        check("stream_pc3", pc_at(3), 32'hC);
        check("stream_lat", 32'(edge_at(0) - rel), 32'd3);
        check("stream_rate", 32'(edge_at(3) - rel), 32'd6);

        // Backpressure fills exactly DEPTH entries and stalls requests.
        do_reset(1, 1'b0);
        cyc(10);
        #1;
        check("bp_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("bp_instr_valid", 32'(bus.instr_valid), 32'h1);
        check("bp_head_pc", bus.instr_pc, 32'h0);
        check("bp_head_instr", bus.instr, 32'hFFFF_FFFF);
        check("bp_fires", 32'(fire_cnt), 32'd2);
        bus.instr_ready = 1'b1;
        cyc(6);
        check("bp_pc0", pc_at(0), 32'h0);
        check("bp_pc1", pc_at(1), 32'h4);
        check("bp_pc2", pc_at(2), 32'h8);
        check("bp_back2back", 32'(edge_at(2) - edge_at(0)), 32'd2);

        // Redirect with two requests in flight at latency 3.
        do_reset(3, 1'b1);
        cyc(2);
        check("rd_inflight", 32'(fire_cnt), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        check("rd_withdraw", 32'(bus.imem_req_valid), 32'h0);
        clear_log();
        cyc(1);
        bus.redirect_valid = 1'b0;
        #1;
        check("rd_new_addr", bus.imem_req_addr, 32'h100);
        cyc(15);
        check("rd_pc0", pc_at(0), 32'h100);
        check("rd_pc1", pc_at(1), 32'h104);

        // Redirect coinciding with a pop of pc 8.
        do_reset(1, 1'b1);
        cyc(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        check("rp_head_pc", bus.instr_pc, 32'h8);
        check("rp_no_valid", 32'(bus.instr_valid), 32'h0);
        clear_log();
        cyc(1);
        bus.redirect_valid = 1'b0;
        cyc(8);
        check("rp_pc0", pc_at(0), 32'h40);
        check("rp_pc1", pc_at(1), 32'h44);

        // Misaligned redirect halts fetch until an aligned redirect.
        redirect_to(32'h202);
        #1;
        check("mis_fault", 32'(bus.fetch_fault), 32'h1);
        cyc(20);
        check("mis_no_fetch", 32'(fire_cnt), 32'h0);
        check("mis_no_pop", 32'(pop_pc.size()), 32'h0);
        check("mis_fault_hold", 32'(bus.fetch_fault), 32'h1);
        redirect_to(32'h200);
        #1;
        check("mis_clear", 32'(bus.fetch_fault), 32'h0);
        check("mis_resume_valid", 32'(bus.imem_req_valid), 32'h1);
        check("mis_resume_addr", bus.imem_req_addr, 32'h200);
        cyc(8);
        check("mis_pc0", pc_at(0), 32'h200);
        check("mis_pc1", pc_at(1), 32'h204);

        // Address wrap, then asynchronous reset mid-stream.
        redirect_to(32'hFFFF_FFF8);
        cyc(8);
        check("wrap_pc0", pc_at(0), 32'hFFFF_FFF8);
        check("wrap_pc1", pc_at(1), 32'hFFFF_FFFC);
        check("wrap_pc2", pc_at(2), 32'h0000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("arst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("arst_instr", bus.instr, 32'h0);
        check("arst_instr_pc", bus.instr_pc, 32'h0);
        check("arst_req_addr", bus.imem_req_addr, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        rel   = ecount;
        clear_log();
        cyc(8);
        check("arst_pc0", pc_at(0), 32'h0);
        check("arst_pc1", pc_at(1), 32'h4);
        check("arst_lat", 32'(edge_at(0) - rel), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
